find_topk_peaks: RTL and testbench
==================================

// Module: find_topk_peaks
// PURPOSE
//  Streaming top-K finder for magnitude spectra, e.g. the CORDIC amplitude output.
//  Tracks the K largest samples of each tlast-delimited frame, with their in-frame indices.
//  At frame end it emits them in rank order as a K-beat AXI-stream packet.
//  Successor to the fixed 3-output max finder: K is a parameter, output is a serial
//  handshaked stream, and unfilled slots and index overflow are flagged.
// PARAMETERS
//  DATA_WIDTH  8  unsigned magnitude width
//  ADDR_WIDTH  6  in-frame sample index width
//  TOP_K       3  number of ranked results per frame (1..16)
// PORTS
//  clk            in   1           clock
//  rst            in   1           reset, synchronous, active-high
//  s_axis_tvalid  in   1           input beat valid
//  s_axis_tlast   in   1           last beat of frame
//  s_axis_tdata   in   DATA_WIDTH  unsigned magnitude
//  s_axis_tready  out  1           input ready
//  m_axis_tready  in   1           downstream ready
//  m_axis_tvalid  out  1           result valid
//  m_axis_tlast   out  1           asserted on rank TOP_K-1 beat
//  m_axis_tdata   out  DATA_WIDTH  ranked magnitude
//  m_axis_taddr   out  ADDR_WIDTH  in-frame index of that magnitude
//  m_axis_tuser   out  2           {frame_ovf, slot_valid}
// BEHAVIOUR
//  - Reset: all outputs 0 except s_axis_tready=1. Slots cleared. idx=0, ovf=0. State COLLECT.
//  - States:
//    - COLLECT: s_axis_tready=1. Each accepted beat is compared in parallel against all
//      slots and inserted into the sorted slot array in the same cycle. Lower-ranked slots
//      shift down and slot K-1 is dropped.
//    - COLLECT -> DRAIN on the cycle after a tlast beat is accepted. Alternative path:
//      COLLECT -> FLUSH -> DRAIN, see CONFIGURATION.
//    - DRAIN: s_axis_tready=0. Emits ranks 0..K-1, one per handshake (tvalid & tready).
//      m_axis_tvalid is asserted the first cycle in DRAIN, i.e. 1 cycle after the tlast
//      beat is accepted.
//    - DRAIN -> COLLECT after the rank K-1 handshake. Slots, idx and ovf are cleared in
//      that same cycle.
//  - Ordering: descending magnitude. Ties go to the earlier index; a new sample displaces
//    a slot only if it is strictly greater.
//  - Empty slot (frame shorter than K, or peak filter rejects): slot is emitted with
//    tdata=0, taddr=0, slot_valid=0. The packet is always exactly TOP_K beats.
//  - Index counter: idx increments per accepted beat. It saturates at 2^ADDR_WIDTH-1;
//    a beat arriving at saturation sets the sticky ovf. ovf is reported on every beat of
//    that frame's packet.
//  - Output is held stable while tvalid=1 and tready=0.
//  - Input arriving during DRAIN is stalled, never dropped.
//  - A 1-beat frame is legal: rank 0 valid, remaining ranks empty.
//  - Reset mid-frame or mid-DRAIN: partial results are discarded and the packet is not
//    completed. Outputs take reset values on the next edge.
// CONFIGURATION
//  - Macro FIND_TOPK_LOCAL_PEAK_EN.
//  - Defined:
//    - Only local maxima are ranked: sample i qualifies if x[i] > x[i-1] and x[i] >= x[i+1].
//      Out-of-frame neighbours are treated as 0.
//    - Candidate i is evaluated when beat i+1 is accepted.
//    - After the tlast beat, a FLUSH state (1 cycle, s_axis_tready=0) evaluates the final
//      sample, then goes to DRAIN. First-result latency is 2 cycles after tlast.
//  - Undefined: every sample is a candidate, FLUSH does not exist, latency is 1 cycle.
// STRUCTURE
//  - Package find_max_pkg: state encodings (COLLECT/FLUSH/DRAIN), slot field widths,
//    tuser bit positions (USER_VALID=0, USER_OVF=1).
//  - Sub-module topk_slot: one ranked cell holding {valid, data, addr}.
//    - Inputs: new sample, own "new wins" compare, upstream neighbour's slot and compare.
//    - Actions: load new, shift from above, or hold.
//    - Instantiated TOP_K times via generate.
// TESTING
//  1. K=3, frame 2C 2D 2E 2F 2F 2D 2E 2D 2D 2C, tlast on beat 9, tready=1 ->
//     (2F,3,v)(2F,4,v)(2E,2,v), tlast on 3rd beat, tuser.ovf=0.
//  2. Same frame with FIND_TOPK_LOCAL_PEAK_EN ->
//     (2F,3,v)(2E,6,v)(00,0,invalid), first tvalid 2 cycles after tlast.
//  3. 1-beat frame 0x40 with tlast -> (40,0,v)(00,0,inv)(00,0,inv);
//     s_axis_tready=0 for 3 cycles, then 1.
//  4. Backpressure: tready toggles 1,0,0,1,... during DRAIN -> data stable while stalled;
//     the next frame's beats are stalled, not lost.
//  5. ADDR_WIDTH=3, 10-beat frame with max value on beat 9 -> that beat reported with
//     taddr=7, tuser.ovf=1 on all beats.
//  6. rst asserted for 1 cycle after rank 0 handshake -> no further tvalid.
//     The next frame ranks correctly, with no stale slots.

Source files
------------

// File: rtl/find_max_pkg.sv
// Shared definitions for the streaming top-K peak finder.
// Holds the FSM state encoding, default slot field widths and tuser bit positions.
// Optional feature macro used by the top: FIND_TOPK_LOCAL_PEAK_EN.
package find_max_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned TOP_K_DEF  = 3;
  localparam int unsigned TOP_K_MAX  = 16;

  localparam int unsigned USER_WIDTH = 2;
  localparam int unsigned USER_VALID = 0;
  localparam int unsigned USER_OVF   = 1;

endpackage

// File: rtl/topk_slot.sv
// One ranked cell of the top-K table, holding {valid, data, addr}.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 end-of-packet clear
//   shift_up            drain: take the slot below (moves ranks toward the output)
//   win                 candidate beats this slot
//   up_win              candidate also beats the slot above (so this slot takes the one above)
//   new_*               candidate sample
//   up_*, dn_*          neighbouring slot contents
//   slot_*              current slot contents
module topk_slot
  import find_max_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_up,
  input  logic                  win,
  input  logic                  up_win,
  input  logic [DATA_WIDTH-1:0] new_data,
  input  logic [ADDR_WIDTH-1:0] new_addr,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic [ADDR_WIDTH-1:0] up_addr,
  input  logic                  dn_valid,
  input  logic [DATA_WIDTH-1:0] dn_data,
  input  logic [ADDR_WIDTH-1:0] dn_addr,
  output logic                  slot_valid,
  output logic [DATA_WIDTH-1:0] slot_data,
  output logic [ADDR_WIDTH-1:0] slot_addr
);

  // Load new, shift down from above on insertion, shift up while draining, or hold.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot_valid <= 1'b0;
      slot_data  <= '0;
      slot_addr  <= '0;
    end else if (shift_up) begin
      slot_valid <= dn_valid;
      slot_data  <= dn_data;
      slot_addr  <= dn_addr;
    end else if (win) begin
      if (up_win) begin
        slot_valid <= up_valid;
        slot_data  <= up_data;
        slot_addr  <= up_addr;
      end else begin
        slot_valid <= 1'b1;
        slot_data  <= new_data;
        slot_addr  <= new_addr;
      end
    end
  end

endmodule

// File: rtl/find_topk_peaks.sv
// Streaming top-K finder: ranks the TOP_K largest samples of each tlast-delimited
// frame and emits them, largest first, as a TOP_K-beat AXI-stream packet.
// Build option: FIND_TOPK_LOCAL_PEAK_EN ranks only local maxima (adds a FLUSH cycle).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_tvalid/tlast/tdata     input magnitudes;  s_axis_tready input ready
//   m_axis_tready                 downstream ready
//   m_axis_tvalid/tlast           result beat valid / last rank
//   m_axis_tdata/taddr            ranked magnitude and its in-frame index
//   m_axis_tuser                  {frame_ovf, slot_valid}
module find_topk_peaks
  import find_max_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned TOP_K      = TOP_K_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [ADDR_WIDTH-1:0] m_axis_taddr,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int unsigned RANK_W = $clog2(TOP_K + 1);
  localparam logic [RANK_W-1:0]     RANK_LAST = RANK_W'(TOP_K - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_MAX   = '1;

  state_t            state_q, state_d;
  logic [RANK_W-1:0] rank_q, rank_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              shift_up, clr;
  logic              s_fire, m_fire;

  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  sat_q, ovf_q;

  logic                  cand_en;
  logic [DATA_WIDTH-1:0] cand_data;
  logic [ADDR_WIDTH-1:0] cand_addr;

  logic [TOP_K-1:0]      win_c;
  logic [TOP_K-1:0]      slot_vld;
  logic [DATA_WIDTH-1:0] slot_dat [TOP_K];
  logic [ADDR_WIDTH-1:0] slot_adr [TOP_K];

  assign s_fire = s_axis_tvalid & s_ready_q;
  assign m_fire = m_valid_q & m_axis_tready;

  // State and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_COLLECT;
      rank_q    <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rank_q    <= rank_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  // Next state; drain walks the ranks by shifting the table toward slot 0.
  always_comb begin
    state_d  = state_q;
    rank_d   = rank_q;
    shift_up = 1'b0;
    clr      = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (s_fire && s_axis_tlast) begin
`ifdef FIND_TOPK_LOCAL_PEAK_EN
          state_d = ST_FLUSH;
`else
          state_d = ST_DRAIN;
`endif
          rank_d = '0;
        end
      end
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (m_fire) begin
          if (rank_q == RANK_LAST) begin
            state_d = ST_COLLECT;
            rank_d  = '0;
            clr     = 1'b1;
          end else begin
            rank_d   = rank_q + RANK_W'(1);
            shift_up = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_COLLECT;
        rank_d  = '0;
      end
    endcase
    s_ready_d = (state_d == ST_COLLECT);
    m_valid_d = (state_d == ST_DRAIN);
    m_last_d  = m_valid_d && (rank_d == RANK_LAST);
  end

  // In-frame index: saturates at IDX_MAX; any beat after the saturated one flags overflow.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx_q <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (s_fire) begin
      if (sat_q) begin
        ovf_q <= 1'b1;
      end else if (idx_q == IDX_MAX) begin
        sat_q <= 1'b1;
      end else begin
        idx_q <= idx_q + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef FIND_TOPK_LOCAL_PEAK_EN
  // Sample i is held until beat i+1 (or FLUSH) supplies its right-hand neighbour.
  logic [DATA_WIDTH-1:0] prev_q, cur_data_q, nxt_data;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic                  cur_have_q;

  always_comb begin
    nxt_data  = (state_q == ST_FLUSH) ? '0 : s_axis_tdata;
    cand_en   = cur_have_q && (s_fire || (state_q == ST_FLUSH)) &&
                (cur_data_q > prev_q) && (cur_data_q >= nxt_data);
    cand_data = cur_data_q;
    cand_addr = cur_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev_q     <= '0;
      cur_data_q <= '0;
      cur_addr_q <= '0;
      cur_have_q <= 1'b0;
    end else if (s_fire) begin
      prev_q     <= cur_data_q;
      cur_data_q <= s_axis_tdata;
      cur_addr_q <= idx_q;
      cur_have_q <= 1'b1;
    end
  end
`else
  assign cand_en   = s_fire;
  assign cand_data = s_axis_tdata;
  assign cand_addr = idx_q;
`endif

  // Sorted slot table; strict compare keeps the earlier index ahead on ties.
  for (genvar g = 0; g < TOP_K; g++) begin : g_slot
    logic                  up_win, up_valid, dn_valid;
    logic [DATA_WIDTH-1:0] up_data, dn_data;
    logic [ADDR_WIDTH-1:0] up_addr, dn_addr;

    assign win_c[g] = cand_en & (~slot_vld[g] | (cand_data > slot_dat[g]));

    if (g == 0) begin : g_first
      assign up_win   = 1'b0;
      assign up_valid = 1'b0;
      assign up_data  = '0;
      assign up_addr  = '0;
    end else begin : g_inner_up
      assign up_win   = win_c[g-1];
      assign up_valid = slot_vld[g-1];
      assign up_data  = slot_dat[g-1];
      assign up_addr  = slot_adr[g-1];
    end

    if (g == TOP_K - 1) begin : g_last
      assign dn_valid = 1'b0;
      assign dn_data  = '0;
      assign dn_addr  = '0;
    end else begin : g_inner_dn
      assign dn_valid = slot_vld[g+1];
      assign dn_data  = slot_dat[g+1];
      assign dn_addr  = slot_adr[g+1];
    end

    topk_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .shift_up   (shift_up),
      .win        (win_c[g]),
      .up_win     (up_win),
      .new_data   (cand_data),
      .new_addr   (cand_addr),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_addr    (up_addr),
      .dn_valid   (dn_valid),
      .dn_data    (dn_data),
      .dn_addr    (dn_addr),
      .slot_valid (slot_vld[g]),
      .slot_data  (slot_dat[g]),
      .slot_addr  (slot_adr[g])
    );
  end

  assign s_axis_tready            = s_ready_q;
  assign m_axis_tvalid            = m_valid_q;
  assign m_axis_tlast             = m_last_q;
  assign m_axis_tdata             = slot_dat[0];
  assign m_axis_taddr             = slot_adr[0];
  assign m_axis_tuser[USER_VALID] = slot_vld[0];
  assign m_axis_tuser[USER_OVF]   = ovf_q;

endmodule

// File: tb/tb_find_topk_peaks.sv
// Directed, table-driven bench for find_topk_peaks (K=3), plus a narrow-index instance
// for the overflow case. Expectations follow FIND_TOPK_LOCAL_PEAK_EN when defined.
module tb_find_topk_peaks;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 6;
  localparam int unsigned AW2 = 3;
  localparam int unsigned K   = 3;

`ifdef FIND_TOPK_LOCAL_PEAK_EN
  localparam int unsigned EXP_WAIT  = 1;
  localparam int unsigned READY_LOW = 4;
`else
  localparam int unsigned EXP_WAIT  = 0;
  localparam int unsigned READY_LOW = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          s_tvalid, s_tlast, s_tready, m_tready, m_tvalid, m_tlast;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [AW-1:0] m_taddr;
  logic [1:0]    m_tuser;

  logic           s2_tvalid, s2_tlast, s2_tready, m2_tready, m2_tvalid, m2_tlast;
  logic [DW-1:0]  s2_tdata, m2_tdata;
  logic [AW2-1:0] m2_taddr;
  logic [1:0]     m2_tuser;

  int nvec = 0;
  int nmiss = 0;

  always #5 clk = ~clk;

  find_topk_peaks #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOP_K(K)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
    .s_axis_tready(s_tready), .m_axis_tready(m_tready), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata), .m_axis_taddr(m_taddr),
    .m_axis_tuser(m_tuser)
  );

  find_topk_peaks #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW2), .TOP_K(K)) u_dut_small (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s2_tvalid), .s_axis_tlast(s2_tlast), .s_axis_tdata(s2_tdata),
    .s_axis_tready(s2_tready), .m_axis_tready(m2_tready), .m_axis_tvalid(m2_tvalid),
    .m_axis_tlast(m2_tlast), .m_axis_tdata(m2_tdata), .m_axis_taddr(m2_taddr),
    .m_axis_tuser(m2_tuser)
  );

  typedef struct {
    int unsigned   len;
    logic [DW-1:0] smp [10];
    logic [DW-1:0] ed  [K];
    logic [AW-1:0] ea  [K];
    logic [K-1:0]  ev;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait (bounded) until it is accepted.
  task automatic push(input logic [DW-1:0] d, input logic l);
    int g;
    g = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!s_tready && g < 60) begin
      step();
      g++;
    end
    if (g >= 60) chk("push timeout", 32'(s_tready), 32'd1);
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int vi);
    for (int i = 0; i < int'(vecs[vi].len); i++)
      push(vecs[vi].smp[i], 1'(i == int'(vecs[vi].len) - 1));
  endtask

  // Collect a packet with tready held high and compare every beat.
  task automatic pull(input int vi, input string tag);
    for (int r = 0; r < int'(K); r++) begin
      int g;
      g = 0;
      while (!m_tvalid && g < 20) begin
        step();
        g++;
      end
      chk($sformatf("%s r%0d tvalid", tag, r), 32'(m_tvalid), 32'd1);
      chk($sformatf("%s r%0d tdata", tag, r), 32'(m_tdata), 32'(vecs[vi].ed[r]));
      chk($sformatf("%s r%0d taddr", tag, r), 32'(m_taddr), 32'(vecs[vi].ea[r]));
      chk($sformatf("%s r%0d tuser", tag, r), 32'(m_tuser), 32'({1'b0, vecs[vi].ev[r]}));
      chk($sformatf("%s r%0d tlast", tag, r), 32'(m_tlast), 32'(r == int'(K) - 1));
      step();
    end
  endtask

  // Collect a packet with tready pattern 1,0,0,1,... checking the output holds while stalled.
  task automatic pull_bp(input int vi);
    logic [3:0]  pat;
    int          r, cyc;
    logic        stalled;
    logic [31:0] held, cur;
    pat = 4'b1001;
    r = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (r < int'(K) && cyc < 60) begin
      m_tready = pat[cyc % 4];
      cur = 32'({m_tvalid, m_tlast, m_tuser, m_taddr, m_tdata});
      if (stalled) chk($sformatf("bp hold c%0d", cyc), cur, held);
      if (m_tvalid && m_tready) begin
        chk($sformatf("bp r%0d tdata", r), 32'(m_tdata), 32'(vecs[vi].ed[r]));
        chk($sformatf("bp r%0d taddr", r), 32'(m_taddr), 32'(vecs[vi].ea[r]));
        chk($sformatf("bp r%0d tuser", r), 32'(m_tuser), 32'({1'b0, vecs[vi].ev[r]}));
        chk($sformatf("bp r%0d tlast", r), 32'(m_tlast), 32'(r == int'(K) - 1));
        r++;
      end
      stalled = m_tvalid && !m_tready;
      held = cur;
      step();
      cyc++;
    end
    chk("bp beats", 32'(r), 32'(K));
    m_tready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0]  e5d [K];
    logic [AW2-1:0] e5a [K];
    logic [1:0]     e5u [K];
    int             cnt;
    logic           seen;

    // Frame table: samples, then expected ranks 0..K-1 (data, index, valid bits).
    vecs[0].len = 10;
    vecs[0].smp = '{8'h2C, 8'h2D, 8'h2E, 8'h2F, 8'h2F, 8'h2D, 8'h2E, 8'h2D, 8'h2D, 8'h2C};
    vecs[1].len = 1;
    vecs[1].smp = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].ed  = '{8'h40, 8'h00, 8'h00};
    vecs[1].ea  = '{6'd0, 6'd0, 6'd0};
    vecs[1].ev  = 3'b001;
    vecs[2].len = 2;
    vecs[2].smp = '{8'h05, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].len = 5;
    vecs[3].smp = '{8'h30, 8'h30, 8'h10, 8'h30, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef FIND_TOPK_LOCAL_PEAK_EN
    vecs[0].ed = '{8'h2F, 8'h2E, 8'h00};
    vecs[0].ea = '{6'd3, 6'd6, 6'd0};
    vecs[0].ev = 3'b011;
    vecs[2].ed = '{8'h09, 8'h00, 8'h00};
    vecs[2].ea = '{6'd1, 6'd0, 6'd0};
    vecs[2].ev = 3'b001;
    vecs[3].ed = '{8'h30, 8'h30, 8'h00};
    vecs[3].ea = '{6'd0, 6'd3, 6'd0};
    vecs[3].ev = 3'b011;
    e5d = '{8'h50, 8'h00, 8'h00};
    e5a = '{3'd7, 3'd0, 3'd0};
    e5u = '{2'b11, 2'b10, 2'b10};
`else
    vecs[0].ed = '{8'h2F, 8'h2F, 8'h2E};
    vecs[0].ea = '{6'd3, 6'd4, 6'd2};
    vecs[0].ev = 3'b111;
    vecs[2].ed = '{8'h09, 8'h05, 8'h00};
    vecs[2].ea = '{6'd1, 6'd0, 6'd0};
    vecs[2].ev = 3'b011;
    vecs[3].ed = '{8'h30, 8'h30, 8'h30};
    vecs[3].ea = '{6'd0, 6'd1, 6'd3};
    vecs[3].ev = 3'b111;
    e5d = '{8'h50, 8'h18, 8'h17};
    e5a = '{3'd7, 3'd7, 3'd7};
    e5u = '{2'b11, 2'b11, 2'b11};
`endif

    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
    s2_tvalid = 1'b0; s2_tlast = 1'b0; s2_tdata = '0; m2_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst s_tready", 32'(s_tready), 32'd1);
    chk("rst m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst m_tlast", 32'(m_tlast), 32'd0);
    chk("rst m_tdata", 32'(m_tdata), 32'd0);
    chk("rst m_taddr", 32'(m_taddr), 32'd0);
    chk("rst m_tuser", 32'(m_tuser), 32'd0);

    // Table frames with an always-ready sink
    for (int vi = 0; vi < 4; vi++) begin
      send_frame(vi);
      cnt = 0;
      while (!m_tvalid && cnt < 10) begin
        step();
        cnt++;
      end
      chk($sformatf("v%0d latency", vi), 32'(cnt), 32'(EXP_WAIT));
      pull(vi, $sformatf("v%0d", vi));
      chk($sformatf("v%0d s_tready after", vi), 32'(s_tready), 32'd1);
    end

    // 1-beat frame: input side stalls for the whole flush/drain
    send_frame(1);
    cnt = 0;
    while (!s_tready && cnt < 10) begin
      step();
      cnt++;
    end
    chk("1beat s_tready low cycles", 32'(cnt), 32'(READY_LOW));

    // Backpressure on the output while the next frame is offered
    send_frame(0);
    fork
      pull_bp(0);
      send_frame(2);
    join
    pull(2, "bp_next");

    // Index saturation on the 3-bit instance
    for (int i = 0; i < 10; i++) begin
      s2_tvalid = 1'b1;
      s2_tdata  = (i == 9) ? 8'h50 : DW'(32'h10 + i);
      s2_tlast  = 1'(i == 9);
      chk($sformatf("ovf s_tready b%0d", i), 32'(s2_tready), 32'd1);
      step();
    end
    s2_tvalid = 1'b0;
    s2_tlast  = 1'b0;
    for (int r = 0; r < int'(K); r++) begin
      cnt = 0;
      while (!m2_tvalid && cnt < 20) begin
        step();
        cnt++;
      end
      chk($sformatf("ovf r%0d tvalid", r), 32'(m2_tvalid), 32'd1);
      chk($sformatf("ovf r%0d tdata", r), 32'(m2_tdata), 32'(e5d[r]));
      chk($sformatf("ovf r%0d taddr", r), 32'(m2_taddr), 32'(e5a[r]));
      chk($sformatf("ovf r%0d tuser", r), 32'(m2_tuser), 32'(e5u[r]));
      chk($sformatf("ovf r%0d tlast", r), 32'(m2_tlast), 32'(r == int'(K) - 1));
      step();
    end

    // Reset right after the rank-0 handshake abandons the packet
    send_frame(0);
    cnt = 0;
    while (!m_tvalid && cnt < 10) begin
      step();
      cnt++;
    end
    chk("rst6 first tvalid", 32'(m_tvalid), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen = seen | m_tvalid;
      step();
    end
    chk("rst6 no tvalid after reset", 32'(seen), 32'd0);
    chk("rst6 s_tready", 32'(s_tready), 32'd1);
    send_frame(2);
    pull(2, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
